qsqrt: RTL
==========

Name: qsqrt

Overview:
- Sequential fixed-point square root in (Q,N) sign-magnitude format. It sits directly downstream of the fixed-point divider in the inverse-kinematics datapath.
- Consumes the divider's quotient (e.g. cos θ) after the 1−c² term is formed, producing sin θ = sqrt(1−c²) for the angle stage.
- Uses the same start/complete handshake as the divider. It is an iterative restoring digit-by-digit root: 2 radicand bits per cycle.

Parameters:
- Q, 15, number of fractional bits.
- N, 32, total word width: bit N-1 is the sign, bits N-2:0 are the magnitude.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_radicand  in  N  operand, sign-magnitude (Q,N).
- i_start  in  1  start request; sampled only while idle.
- o_root_out  out  N  result, sign-magnitude (Q,N); sign bit always 0.
- o_complete  out  1  1 = idle/result valid; 0 = busy.
- o_error  out  1  1 = last operand was negative non-zero.

Behaviour:
- Constants:
  - RAD_W = N-1+Q.
  - ITER = (RAD_W+1)/2 (23 for the defaults).
  - Count register width is clog2(ITER+1).
- Reset (rst=0 at a rising edge) has priority over everything, including mid-operation. Reset values:
  - o_complete=1, o_error=0, o_root_out=0.
  - Working registers and counter cleared.
- FSM states:
  - IDLE: o_complete=1.
  - RUN: o_complete=0.
- IDLE→RUN when i_start=1 at an edge and the operand is non-negative. Non-negative means sign=0, or sign=1 with magnitude 0.
  - Latch radicand R = magnitude << Q (RAD_W bits; pad to 2*ITER bits with a leading zero if RAD_W is odd).
  - Clear remainder and root; counter = ITER-1; o_error <= 0.
- Negative operand (sign=1, magnitude≠0) with i_start=1 in IDLE:
  - Stay in IDLE; o_complete stays 1.
  - Next edge: o_error=1, o_root_out=0.
- RUN, each cycle:
  - Shift the next 2 MSBs of R into the remainder: rem' = (rem<<2)|R[top2].
  - Trial value t = (root<<2)|1.
  - If rem' >= t: rem = rem'-t and root = (root<<1)|1.
  - Else: rem = rem' and root = root<<1.
  - Remainder width is ITER+2 bits; no overflow is possible.
- RUN termination: on the cycle where counter==0 and the final step is done, go to IDLE.
  - o_root_out[N-2:0] <= root, zero-extended; o_root_out[N-1] <= 0.
  - o_complete=1 from that edge onward.
- RUN otherwise: counter decrements by 1.
- Latency: start accepted at edge k → o_complete=0 after k; o_complete=1 after edge k+ITER (exactly ITER busy cycles).
- Result:
  - Value is floor(sqrt(magnitude·2^Q)), i.e. truncating. No rounding.
  - Always fits in N-1 bits, so there is no overflow output.
- i_start while in RUN is ignored; the in-flight operation is unaffected.
- i_start held high in IDLE starts a new operation each time IDLE is re-entered. Back-to-back throughput is one result per ITER+1 cycles.
- o_root_out and o_error hold their value until the next accepted start or reset.
  - o_root_out changes only at termination or on the negative-operand path.
  - An accepted non-negative start clears o_error immediately. o_root_out keeps the old value until termination.
- Zero input (0x00000000 or 0x80000000) → o_root_out=0, o_error=0, after the full ITER cycles.

Decomposition:
- Shared fixed-point package holds:
  - The Q/N defaults.
  - Derived constants RAD_W and ITER.
  - The sign-magnitude field positions (SIGN_BIT = N-1, MAG_MSB = N-2).
- One combinational sub-module, qsqrt_step:
  - Inputs: rem, root, next 2 radicand bits.
  - Outputs: new rem, new root.
  - Instantiated once; the FSM, counter and handshake live in qsqrt.

Test Plan:
- 0x00008000 (1.0), start pulse → o_complete low exactly 23 cycles, then o_root_out=0x00008000, o_error=0.
- 0x00020000 (4.0) → 0x00010000; 0x00002000 (0.25) → 0x00004000.
- 0x00010000 (2.0) → 0x0000B504 (floor 46340.95). Then 0x7FFFFFFF → 0x007FFFFF.
- 0x80008000 (−1.0) → o_complete never drops, o_error=1, o_root_out=0. A following start with 0x00008000 clears o_error and returns 0x00008000.
- Start 0x00020000, pulse i_start with 0x00008000 at busy cycle 5 → ignored, result 0x00010000. Then rst=0 at busy cycle 10 of a new op → next cycle o_complete=1, o_root_out=0, o_error=0.
- 0x80000000 (−0) → no error, full 23-cycle run, o_root_out=0.

Source files
------------

// File: rtl/qsqrt_pkg.sv
// Shared fixed-point definitions for the (Q,N) sign-magnitude root stage:
// format defaults, derived iteration constants and the FSM state type.
package qsqrt_pkg;

  localparam int Q_DEF = 15;
  localparam int N_DEF = 32;

  localparam int SIGN_BIT = N_DEF - 1;
  localparam int MAG_MSB  = N_DEF - 2;

  function automatic int calc_rad_w(input int q, input int n);
    return n - 1 + q;
  endfunction

  // Two radicand bits are consumed per iteration, so an odd width rounds up.
  function automatic int calc_iter(input int q, input int n);
    return (calc_rad_w(q, n) + 1) / 2;
  endfunction

  localparam int RAD_W = calc_rad_w(Q_DEF, N_DEF);
  localparam int ITER  = calc_iter(Q_DEF, N_DEF);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/qsqrt_step.sv
// One restoring digit-by-digit square-root step: brings in two radicand
// bits, tries (root<<2)|1 against the remainder and emits the next root bit.
module qsqrt_step #(
  parameter int ITER = 23
) (
  input  logic [ITER+1:0] rem,
  input  logic [ITER-1:0] root,
  input  logic [1:0]      bits,
  output logic [ITER+1:0] rem_next,
  output logic [ITER-1:0] root_next
);

  localparam int REM_W = ITER + 2;

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             ge;

  // The remainder never exceeds 2*root, so the bits shifted out are zero.
  always_comb begin
    rem_sh    = (rem << 2) | REM_W'(bits);
    trial     = (REM_W'(root) << 2) | REM_W'(1);
    ge        = (rem_sh >= trial);
    rem_next  = ge ? (rem_sh - trial) : rem_sh;
    root_next = (root << 1) | ITER'(ge);
  end

endmodule

// File: rtl/qsqrt.sv
// Iterative fixed-point square root (Q,N sign-magnitude) with the divider's
// start/complete handshake; one result every ITER busy cycles.
module qsqrt
  import qsqrt_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic [N-1:0] i_radicand,
  input  logic         i_start,
  output logic [N-1:0] o_root_out,
  output logic         o_complete,
  output logic         o_error,
  output state_t       dbg_state
);

  // Handshake: i_start is sampled only while o_complete=1 (idle). An accepted
  // start drops o_complete on the next edge; o_complete rising marks
  // o_root_out/o_error valid, and they hold until the next accepted start.

  localparam int R_W     = calc_rad_w(Q, N);
  localparam int IT      = calc_iter(Q, N);
  localparam int RAD2_W  = 2 * IT;
  localparam int REM_W   = IT + 2;
  localparam int CNT_W   = $clog2(IT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [RAD2_W-1:0]   rad;
  logic [RAD2_W-1:0]   rad_init;
  logic [REM_W-1:0]    rem;
  logic [REM_W-1:0]    rem_nxt;
  logic [IT-1:0]       root;
  logic [IT-1:0]       root_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [N-2:0]        mag;
  logic                neg;
  logic                accept;
  logic                reject;

  assign mag      = i_radicand[N-2:0];
  // Negative zero is treated as a valid zero operand.
  assign neg      = i_radicand[N-1] & (|mag);
  assign accept   = (state == ST_IDLE) & i_start & ~neg;
  assign reject   = (state == ST_IDLE) & i_start & neg;
  assign rad_init = RAD2_W'({mag, {Q{1'b0}}});

  assign o_complete = (state == ST_IDLE);
  assign dbg_state  = state;

  qsqrt_step #(
    .ITER(IT)
  ) u_step (
    .rem      (rem),
    .root     (root),
    .bits     (rad[RAD2_W-1 -: 2]),
    .rem_next (rem_nxt),
    .root_next(root_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rad        <= '0;
      rem        <= '0;
      root       <= '0;
      cnt        <= '0;
      o_root_out <= '0;
      o_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rad     <= rad_init;
        rem     <= '0;
        root    <= '0;
        cnt     <= CNT_W'(IT - 1);
        o_error <= 1'b0;
      end else if (reject) begin
        o_error    <= 1'b1;
        o_root_out <= '0;
      end else if (state == ST_RUN) begin
        rad  <= rad << 2;
        rem  <= rem_nxt;
        root <= root_nxt;
        if (cnt == '0) begin
          o_root_out <= {1'b0, (N-1)'(root_nxt)};
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  logic unused_rw;
  assign unused_rw = (R_W > 0);

endmodule
